// File: rtl/fwdpkt.sv
// Store-and-forward packet stage: buffers one RX frame, then replays it into
// every TX FIFO selected by this port's lookup nibble, honouring full flags.
module fwdpkt #(
  parameter int unsigned NPORT    = 4,
  parameter int unsigned PORT_NUM = 0,
  parameter int unsigned MAX_LEN  = 2048,
  parameter int unsigned MIN_LEN  = 50
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [8:0]       in_data,
  input  logic             in_valid,
  input  logic [15:0]      of_lookup_fwd_port,
  output logic [8:0]       tx_din,
  output logic [NPORT-1:0] tx_wr_en,
  input  logic [NPORT-1:0] tx_full,
  output logic             busy,
  output logic [31:0]      stat_fwd_cnt,
  output logic [31:0]      stat_drop_cnt
);

  localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);

  typedef enum logic [2:0] {IDLE, RECV, DROP, DECIDE, SEND} state_t;

  state_t           state;
  logic [7:0]       pkt_buf [MAX_LEN];
  logic [7:0]       rd_q;
  logic [11:0]      len, rd_ptr, rd_addr, wr_addr;
  logic [NPORT-1:0] mask, lk_mask;
  logic             in_frame, is_byte, is_eof, is_start, go, wr_en;
  logic             drop_ovf, drop_dec, drop_busy;

  always_comb begin
    is_byte   = in_valid & in_data[8];
    is_eof    = in_valid & ~in_data[8] & in_frame;
    is_start  = is_byte & ~in_frame;
    lk_mask   = of_lookup_fwd_port[4*PORT_NUM +: NPORT];
    go        = (tx_full & mask) == '0;
    wr_en     = (state == IDLE && is_start) || (state == RECV && is_byte && len != MAX_L);
    wr_addr   = (state == IDLE) ? '0 : len;
    drop_ovf  = (state == RECV) && is_byte && (len == MAX_L);
    drop_dec  = (state == DECIDE) && ((len < MIN_L) || (lk_mask == '0));
    drop_busy = is_start && (state == DECIDE || state == SEND);
    // Read address runs one word ahead so rd_q always holds buf[rd_ptr].
    rd_addr = rd_ptr;
    if (state == DECIDE)
      rd_addr = '0;
    else if (state == SEND && go && rd_ptr != len)
      rd_addr = rd_ptr + 12'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en)
      pkt_buf[wr_addr[AW-1:0]] <= in_data[7:0];
    rd_q <= pkt_buf[rd_addr[AW-1:0]];
  end

  // Frame boundary tracker, independent of the FSM so foreign frames are seen once.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      in_frame <= 1'b0;
    else if (is_byte)
      in_frame <= 1'b1;
    else if (is_eof)
      in_frame <= 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      len           <= '0;
      rd_ptr        <= '0;
      mask          <= '0;
      tx_wr_en      <= '0;
      tx_din        <= '0;
      stat_fwd_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      tx_wr_en      <= '0;
      stat_drop_cnt <= stat_drop_cnt + 32'(drop_ovf) + 32'(drop_dec) + 32'(drop_busy);
      case (state)
        IDLE:
          if (is_start) begin
            len   <= 12'd1;
            state <= RECV;
          end
        RECV:
          if (is_byte) begin
            if (len == MAX_L) state <= DROP;
            else              len   <= len + 12'd1;
          end else if (is_eof) begin
            state <= DECIDE;
          end
        DROP:
          if (is_eof) state <= IDLE;
        DECIDE:
          if (drop_dec) begin
            state <= IDLE;
          end else begin
            mask   <= lk_mask;
            rd_ptr <= '0;
            state  <= SEND;
          end
        SEND:
          if (go) begin
            tx_wr_en <= mask;
            if (rd_ptr != len) begin
              tx_din <= {1'b1, rd_q};
              rd_ptr <= rd_ptr + 12'd1;
            end else begin
              tx_din       <= '0;
              stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
              state        <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fwdpkt.sv
// Directed bench for fwdpkt: frame-level model predicts the TX word stream and
// counters; every cycle the DUT writes are checked against it.
module tb_fwdpkt;
  localparam int unsigned NP  = 4;
  localparam int unsigned PN  = 0;
  localparam int unsigned MXL = 2048;
  localparam int unsigned MNL = 50;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [8:0]  in_data;
  logic        in_valid;
  logic [15:0] fwd_port;
  logic [8:0]  tx_din;
  logic [3:0]  tx_wr_en;
  logic [3:0]  tx_full;
  logic        busy;
  logic [31:0] stat_fwd_cnt, stat_drop_cnt;

  fwdpkt #(.NPORT(NP), .PORT_NUM(PN), .MAX_LEN(MXL), .MIN_LEN(MNL)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
    .of_lookup_fwd_port(fwd_port), .tx_din(tx_din), .tx_wr_en(tx_wr_en),
    .tx_full(tx_full), .busy(busy), .stat_fwd_cnt(stat_fwd_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed { logic [3:0] m; logic [8:0] w; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   exp_fwd = 0, exp_drop = 0;
  logic [3:0] prev_full = '0;
  logic [3:0] obs_wr;
  logic       obs_busy;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  // One clock: compare DUT outputs at negedge, then advance to posedge+1.
  task automatic step();
    exp_t e;
    @(negedge sys_clk);
    obs_wr   = tx_wr_en;
    obs_busy = busy;
    if (tx_wr_en != '0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 32'(tx_wr_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tx_wr_en", 32'(tx_wr_en), 32'(e.m));
        chk("tx_din", 32'(tx_din), 32'(e.w));
      end
      chk("stall_rule", 32'(prev_full & tx_wr_en), 32'd0);
    end
    @(posedge sys_clk);
    prev_full = tx_full;
    #1;
  endtask

  // Frame-level forwarding rule.
  task automatic classify(input int n, input int base, input bit busy_drop);
    logic [3:0] m;
    logic [15:0] fp;
    fp = fwd_port;
    m  = fp[4*PN +: 4] & 4'((1 << NP) - 1);
    if (busy_drop || n > int'(MXL) || n < int'(MNL) || m == 4'h0) begin
      exp_drop++;
    end else begin
      exp_fwd++;
      for (int i = 0; i < n; i++) exp_q.push_back('{m: m, w: {1'b1, 8'(base + i)}});
      exp_q.push_back('{m: m, w: 9'h000});
    end
  endtask

  task automatic send_frame(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = {1'b1, 8'(base + i)};
      step();
    end
    in_valid = 1'b1;
    in_data  = 9'h000;
    step();
    in_valid = 1'b0;
  endtask

  // Drain after EOF with an optional tx_full pattern; reports write-cycle span.
  task automatic run_out(input int budget, input logic [3:0] fm, input int fs, input int fl,
                         input bit tog, output int first, output int last, output int cnt);
    bit done = 0;
    first = -1; last = -1; cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      if (i >= fs && i < fs + fl) tx_full = (tog && i[0]) ? 4'h0 : fm;
      else                        tx_full = 4'h0;
      step();
      if (obs_wr != '0) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      if (i >= 3 && !obs_busy) begin
        done = 1;
        break;
      end
    end
    chk("run_done", 32'(done), 32'd1);
    chk("leftover_words", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_counters();
    chk("stat_fwd_cnt", stat_fwd_cnt, 32'(exp_fwd));
    chk("stat_drop_cnt", stat_drop_cnt, 32'(exp_drop));
  endtask

  initial begin
    int f, l, c;
    sys_rst_n = 1'b0; in_valid = 1'b0; in_data = '0; tx_full = '0; fwd_port = '0;
    @(posedge sys_clk); #1;
    step(); step();
    chk("rst_wr_en", 32'(tx_wr_en), 32'd0);
    chk("rst_din", 32'(tx_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fwd", stat_fwd_cnt, 32'd0);
    chk("rst_drop", stat_drop_cnt, 32'd0);
    sys_rst_n = 1'b1;
    step();

    // 64 bytes, only port 2 selected, no stalls.
    fwd_port = 16'h8884;
    classify(64, 0, 0); send_frame(64, 0);
    run_out(300, 4'h0, 0, 0, 0, f, l, c);
    chk("t1_span", 32'(l - f + 1), 32'd65);
    chk("t1_cnt", 32'(c), 32'd65);
    chk("t1_fwd", stat_fwd_cnt, 32'd1);
    chk_counters();

    // Mask 1011, port 1 full for 5 cycles mid-frame.
    fwd_port = 16'h000B;
    classify(64, 0, 0); send_frame(64, 0);
    run_out(300, 4'b0010, 20, 5, 0, f, l, c);
    chk("t2_span", 32'(l - f + 1), 32'd70);
    chk("t2_cnt", 32'(c), 32'd65);
    chk_counters();

    // Mask 0011, unmasked port 2 toggling full.
    fwd_port = 16'h0003;
    classify(64, 8'h80, 0); send_frame(64, 8'h80);
    run_out(300, 4'b0100, 2, 60, 1, f, l, c);
    chk("t3_span", 32'(l - f + 1), 32'd65);
    chk("t3_cnt", 32'(c), 32'd65);
    chk("t3_fwd", stat_fwd_cnt, 32'd3);
    chk_counters();

    // Undersize frame.
    fwd_port = 16'h0001;
    classify(40, 3, 0); send_frame(40, 3);
    run_out(50, 4'h0, 0, 0, 0, f, l, c);
    chk("t4_cnt", 32'(c), 32'd0);
    chk("t4_drop", stat_drop_cnt, 32'd1);
    chk_counters();

    // Zero mask for this port.
    fwd_port = 16'hFFF0;
    classify(64, 5, 0); send_frame(64, 5);
    run_out(50, 4'h0, 0, 0, 0, f, l, c);
    chk("t5_cnt", 32'(c), 32'd0);
    chk("t5_drop", stat_drop_cnt, 32'd2);
    chk_counters();

    // Oversize frame, then a normal one.
    fwd_port = 16'h000F;
    classify(2049, 7, 0); send_frame(2049, 7);
    run_out(50, 4'h0, 0, 0, 0, f, l, c);
    chk("t6_cnt", 32'(c), 32'd0);
    chk("t6_drop", stat_drop_cnt, 32'd3);
    chk_counters();
    fwd_port = 16'h000C;
    classify(64, 8'h40, 0); send_frame(64, 8'h40);
    run_out(300, 4'h0, 0, 0, 0, f, l, c);
    chk("t7_cnt", 32'(c), 32'd65);
    chk("t7_fwd", stat_fwd_cnt, 32'd4);
    chk_counters();

    // Second frame arrives while the first is stalled in SEND.
    fwd_port = 16'h0001;
    tx_full  = 4'hF;
    classify(64, 8'h10, 0); send_frame(64, 8'h10);
    classify(60, 8'hA0, 1); send_frame(60, 8'hA0);
    run_out(300, 4'h0, 0, 0, 0, f, l, c);
    chk("t8_cnt", 32'(c), 32'd65);
    chk("t8_fwd", stat_fwd_cnt, 32'd5);
    chk("t8_drop", stat_drop_cnt, 32'd4);
    chk_counters();
    classify(64, 8'h20, 0); send_frame(64, 8'h20);
    run_out(300, 4'h0, 0, 0, 0, f, l, c);
    chk("t9_cnt", 32'(c), 32'd65);
    chk_counters();

    // Reset in the middle of SEND.
    fwd_port = 16'h0002;
    classify(64, 8'h33, 0); send_frame(64, 8'h33);
    for (int i = 0; i < 10; i++) step();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    exp_q.delete();
    exp_fwd = 0; exp_drop = 0;
    chk("mrst_wr_en", 32'(tx_wr_en), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_din", 32'(tx_din), 32'd0);
    chk_counters();
    classify(64, 8'h55, 0); send_frame(64, 8'h55);
    run_out(300, 4'h0, 0, 0, 0, f, l, c);
    chk("t10_cnt", 32'(c), 32'd65);
    chk("t10_fwd", stat_fwd_cnt, 32'd1);
    chk_counters();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
